// File: rtl/serial_subtractor.sv
// Multi-cycle LSB-first subtractor: diff = a - b - borrow_in, BITS_PER_CYCLE
// full-subtractor cells per clock with a single borrow flip-flop between steps.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           request, accepted only while ready=1
//   a, b            minuend / subtrahend, sampled on an accepted start
//   borrow_in       incoming borrow, sampled on an accepted start
//   signed_mode     1 = two's-complement overflow rule, 0 = unsigned
//   ready           high in IDLE and DONE
//   busy            high in SHIFT
//   done            one-cycle pulse when results become valid
//   diff            registered result, held until the next completion
//   borrow_out      borrow out of the MSB, held with diff
//   overflow        signed or unsigned overflow of the last operation
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    input  logic             signed_mode,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                state;
    logic [WIDTH-1:0]          a_sr;
    logic [WIDTH-1:0]          b_sr;
    logic [WIDTH-1:0]          r_sr;
    logic                      br;
    logic [CW-1:0]             cnt;
    logic                      mode_q;
    logic                      a_msb;
    logic                      b_msb;

    logic [BITS_PER_CYCLE-1:0] slice;
    logic                      chain_br;
    logic [WIDTH-1:0]          r_next;
    logic                      ovf_next;
    logic                      load;

    // Ripple the borrow through this step's slice of cells.
    always_comb begin
        chain_br = br;
        slice    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            slice[i] = a_sr[i] ^ b_sr[i] ^ chain_br;
            chain_br = (~a_sr[i] & b_sr[i])
                     | (~(a_sr[i] ^ b_sr[i]) & chain_br);
        end
    end

    // New slice enters at the MSB end so that after STEPS shifts the
    // first-computed bits have arrived at the LSB end.
    assign r_next = (r_sr >> BITS_PER_CYCLE)
                  | (WIDTH'(slice) << (WIDTH - BITS_PER_CYCLE));

    // Signed rule uses the latched operand MSBs; borrow_in does not enter it.
    assign ovf_next = mode_q
                    ? ((a_msb ^ b_msb) & (r_next[WIDTH-1] ^ a_msb))
                    : chain_br;

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign busy  = (state == S_SHIFT);
    assign done  = (state == S_DONE);
    assign load  = start && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_SHIFT: begin
                    a_sr <= a_sr >> BITS_PER_CYCLE;
                    b_sr <= b_sr >> BITS_PER_CYCLE;
                    r_sr <= r_next;
                    br   <= chain_br;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= r_next;
                        borrow_out <= chain_br;
                        overflow   <= ovf_next;
                        state      <= S_DONE;
                    end
                end
                default: begin
                    if (load) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        r_sr   <= '0;
                        br     <= borrow_in;
                        cnt    <= '0;
                        mode_q <= signed_mode;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        state  <= S_SHIFT;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: W=8/B=1 directed and random
// operations, plus exhaustive W=4 runs with B=1, 2 and 4.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       mode;
    int         sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic [3:0] st;
    logic [3:0] rdy, bsy, dn, bo, ov;
    logic [7:0] df8;
    logic [3:0] df1, df2, df4;

    assign st = start ? (4'b0001 << sel) : 4'b0000;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b),
        .borrow_in(bin), .signed_mode(mode), .ready(rdy[0]),
        .busy(bsy[0]), .done(dn[0]), .diff(df8),
        .borrow_out(bo[0]), .overflow(ov[0]));

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_w4b1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a[3:0]), .b(b[3:0]),
        .borrow_in(bin), .signed_mode(mode), .ready(rdy[1]),
        .busy(bsy[1]), .done(dn[1]), .diff(df1),
        .borrow_out(bo[1]), .overflow(ov[1]));

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_w4b2 (
        .clk(clk), .rst(rst), .start(st[2]), .a(a[3:0]), .b(b[3:0]),
        .borrow_in(bin), .signed_mode(mode), .ready(rdy[2]),
        .busy(bsy[2]), .done(dn[2]), .diff(df2),
        .borrow_out(bo[2]), .overflow(ov[2]));

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_w4b4 (
        .clk(clk), .rst(rst), .start(st[3]), .a(a[3:0]), .b(b[3:0]),
        .borrow_in(bin), .signed_mode(mode), .ready(rdy[3]),
        .busy(bsy[3]), .done(dn[3]), .diff(df4),
        .borrow_out(bo[3]), .overflow(ov[3]));

    logic       g_rdy, g_bsy, g_dn, g_bo, g_ov;
    logic [7:0] g_df;

    always_comb begin
        g_rdy = rdy[sel];
        g_bsy = bsy[sel];
        g_dn  = dn[sel];
        g_bo  = bo[sel];
        g_ov  = ov[sel];
        case (sel)
            1:       g_df = {4'h0, df1};
            2:       g_df = {4'h0, df2};
            3:       g_df = {4'h0, df4};
            default: g_df = df8;
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int steps_of(input int s);
        case (s)
            1:       return 4;
            2:       return 2;
            3:       return 1;
            default: return 8;
        endcase
    endfunction

    // Reference: plain integer subtraction, wrap to width, borrow is the sign
    // of the exact result, signed overflow from operand/result MSBs.
    task automatic model(input int w, input int av, input int bv,
                         input int bi, input int md,
                         output int d, output int bro, output int ovf);
        int full;
        int am, bm, dm;
        full = av - bv - bi;
        bro  = (full < 0) ? 1 : 0;
        d    = full & ((1 << w) - 1);
        am   = (av >> (w - 1)) & 1;
        bm   = (bv >> (w - 1)) & 1;
        dm   = (d >> (w - 1)) & 1;
        ovf  = md ? ((am != bm && dm != am) ? 1 : 0) : bro;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int s, input int av, input int bv,
                          input int bi, input int md, input string tag);
        int w, steps, n, ed, eb, eo, prev;
        sel   = s;
        steps = steps_of(s);
        w     = (s == 0) ? 8 : 4;
        av    = av & ((1 << w) - 1);
        bv    = bv & ((1 << w) - 1);
        model(w, av, bv, bi, md, ed, eb, eo);
        #0;
        prev  = g_df;
        a     = av[7:0];
        b     = bv[7:0];
        bin   = bi[0];
        mode  = md[0];
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
        mode  = 1'($urandom);
        chk({tag, " busy"}, g_bsy, 1);
        chk({tag, " stale"}, g_df, prev);
        n = 0;
        while (!g_dn && n < steps + 4) begin
            step();
            n++;
        end
        chk({tag, " latency"}, n, steps);
        chk({tag, " diff"}, g_df, ed);
        chk({tag, " borrow"}, g_bo, eb);
        chk({tag, " ovf"}, g_ov, eo);
        chk({tag, " ready"}, g_rdy, 1);
        step();
        chk({tag, " done_drop"}, g_dn, 0);
    endtask

    initial begin
        int cnt_done;
        sel   = 0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        mode  = 1'b0;
        rst   = 1'b1;
        step();
        step();
        chk("rst diff", g_df, 0);
        chk("rst done", g_dn, 0);
        chk("rst busy", g_bsy, 0);
        chk("rst ovf", g_ov, 0);
        rst = 1'b0;
        step();
        chk("rst ready", g_rdy, 1);

        run_op(0, 8'h05, 8'h03, 0, 0, "d05m03");
        run_op(0, 8'h03, 8'h05, 0, 0, "d03m05");
        run_op(0, 8'h00, 8'h00, 1, 0, "d0m0b1");
        run_op(0, 8'h80, 8'h01, 0, 1, "s80m01");
        run_op(0, 8'h7F, 8'hFF, 0, 1, "s7Fm FF");
        run_op(0, 8'hFE, 8'hFF, 0, 1, "sFEmFF");

        // start held high: first op runs, start during SHIFT is ignored,
        // second op is accepted in DONE with no idle cycle.
        sel   = 0;
        a     = 8'h20;
        b     = 8'h03;
        bin   = 1'b0;
        mode  = 1'b0;
        start = 1'b1;
        step();
        cnt_done = 0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i == 1) begin
                a = 8'h10;
                b = 8'h01;
            end
            if (g_dn) cnt_done++;
            if (i == 8) begin
                chk("b2b done1", g_dn, 1);
                chk("b2b diff1", g_df, 8'h1D);
            end
            if (i == 9) chk("b2b busy2", g_bsy, 1);
            if (i == 16) chk("b2b stale", g_df, 8'h1D);
            if (i == 17) begin
                chk("b2b done2", g_dn, 1);
                chk("b2b diff2", g_df, 8'h0F);
                start = 1'b0;
            end
        end
        chk("b2b pulses", cnt_done, 2);
        chk("b2b idle", g_rdy, 1);

        // Reset while mid-SHIFT.
        run_op(0, 8'h05, 8'h03, 0, 0, "pre_rst");
        a     = 8'h03;
        b     = 8'h05;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst diff", g_df, 0);
        chk("mid_rst busy", g_bsy, 0);
        chk("mid_rst bo", g_bo, 0);
        step();
        rst = 1'b0;
        cnt_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (g_dn) cnt_done++;
        end
        chk("mid_rst no_done", cnt_done, 0);
        chk("mid_rst ready", g_rdy, 1);
        chk("mid_rst diff2", g_df, 0);
        run_op(0, 8'h10, 8'h01, 0, 0, "post_rst");

        for (int i = 0; i < 200; i++)
            run_op(0, int'($urandom_range(255)), int'($urandom_range(255)),
                   int'($urandom_range(1)), int'($urandom_range(1)), "rnd8");

        for (int s = 1; s <= 3; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    for (int k = 0; k < 4; k++)
                        run_op(s, x, y, k & 1, k >> 1, "exh4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
